flash_word_arbiter: RTL and testbench

Shares the board's 8-bit parallel flash between the CPU instruction-fetch port and data port. Each accepted request reads one 32-bit big-endian word, assembled from four byte reads. The block sits between the `mips_cpu` fetch/memory stages and the `FL_*` pins. A programmable wait-state counter covers flash access time.

---
 rtl/flash_ctrl_pkg.sv | 31 +++
 rtl/flash_rr_arbiter.sv | 35 +++
 rtl/flash_word_arbiter.sv | 132 +++++++++++++
 tb/tb_flash_word_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared types and helpers for the parallel-flash word reader: FSM encoding, port ids and
// big-endian byte-lane placement.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StByte,
    StDone
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte k of a word lands in the big-endian lane: k=0 is the most significant byte.
  function automatic logic [31:0] set_byte_lane(input logic [31:0] word, input logic [1:0] k,
                                                input logic [7:0] b);
    logic [31:0] res;
    res = word;
    unique case (k)
      2'd0: res[31:24] = b;
      2'd1: res[23:16] = b;
      2'd2: res[15:8]  = b;
      2'd3: res[7:0]   = b;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flash_rr_arbiter.sv
// Two-way round-robin arbiter between the fetch (I) and data (D) ports. The pointer moves only
// when a grant is accepted; out of reset the D port wins the first contention.
module flash_rr_arbiter
  import flash_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) begin
      grant = (last_q == PORT_I) ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
    last_d = last_q;
    if (accept) begin
      last_d = grant[PORT_D] ? PORT_D : PORT_I;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/flash_word_arbiter.sv
// Shares an 8-bit parallel flash between the CPU fetch and data ports, assembling each 32-bit
// big-endian word from four byte reads with a programmable per-byte wait.
module flash_word_arbiter
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned ADDR_W      = 22
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-3:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  input  logic              d_req_valid,
  input  logic [ADDR_W-3:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] FL_ADDR,
  input  logic [7:0]        FL_DQ,
  output logic              FL_CE_N,
  output logic              FL_OE_N,
  output logic              FL_WE_N,
  output logic              FL_RST_N
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);
  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [1:0]        k_q, k_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              fl_rst_n_q;
  logic [1:0]        grant;
  logic              i_hs, d_hs;

  flash_rr_arbiter u_arb (
    .clk     (clk),
    .Reset_n (Reset_n),
    .req     ({d_req_valid, i_req_valid}),
    .accept  (i_hs | d_hs),
    .grant   (grant)
  );

  // Requests stay blocked until the flash itself has been let out of reset.
  assign i_req_ready = (state_q == StIdle) & fl_rst_n_q & grant[PORT_I];
  assign d_req_ready = (state_q == StIdle) & fl_rst_n_q & grant[PORT_D];
  assign i_hs        = i_req_valid & i_req_ready;
  assign d_hs        = d_req_valid & d_req_ready;

  assign i_rsp_valid = (state_q == StDone) & (port_q == PORT_I);
  assign d_rsp_valid = (state_q == StDone) & (port_q == PORT_D);
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != StIdle);

  // Pins decode straight from state so an asynchronous reset releases the flash at once.
  assign FL_ADDR  = (state_q == StByte) ? {addr_q, k_q} : '0;
  assign FL_CE_N  = (state_q != StByte);
  assign FL_OE_N  = (state_q != StByte);
  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = fl_rst_n_q;

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    addr_d     = addr_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (i_hs | d_hs) begin
          addr_d  = d_hs ? d_req_addr : i_req_addr;
          port_d  = d_hs ? PORT_D : PORT_I;
          k_d     = 2'd0;
          cnt_d   = '0;
          state_d = StByte;
        end
      end
      StByte: begin
        if (cnt_q == CntMax) begin
          word_d = set_byte_lane(word_q, k_q, FL_DQ);
          k_d    = k_q + 2'd1;
          cnt_d  = '0;
          if (k_q == LastByte) begin
            rsp_data_d = word_d;
            state_d    = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      port_q     <= PORT_I;
      addr_q     <= '0;
      k_q        <= 2'd0;
      cnt_q      <= '0;
      word_q     <= '0;
      rsp_data_q <= '0;
      fl_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      rsp_data_q <= rsp_data_d;
      fl_rst_n_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_word_arbiter.sv
// Directed bench for flash_word_arbiter: default build plus a WAIT_CYCLES=0 build, each fed by a
// small flash image model.
module tb_flash_word_arbiter;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          t_hs = 0;

  // Default build
  logic        i_req_valid = 1'b0, d_req_valid = 1'b0;
  logic [19:0] i_req_addr = '0, d_req_addr = '0;
  logic        i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, busy;
  logic [31:0] rsp_data;
  logic [21:0] fl_addr;
  logic [7:0]  fl_dq;
  logic        fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n;

  // WAIT_CYCLES=0 build
  logic        i0_req_valid = 1'b0;
  logic [19:0] i0_req_addr = '0;
  logic        i0_req_ready, d0_req_ready, i0_rsp_valid, d0_rsp_valid, busy0;
  logic [31:0] rsp_data0;
  logic [21:0] fl_addr0;
  logic [7:0]  fl_dq0;
  logic        fl_ce_n0, fl_oe_n0, fl_we_n0, fl_rst_n0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] flash_word(input logic [19:0] wa);
    case (wa)
      20'h00010: return 32'h8C220004;
      20'h00001: return 32'h11111111;
      20'h00002: return 32'h22222222;
      20'hFFFFF: return 32'hDEADBEEF;
      default:   return {12'hA5C, wa};
    endcase
  endfunction

  function automatic logic [7:0] flash_byte(input logic [21:0] a);
    logic [31:0] w;
    w = flash_word(a[21:2]);
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign fl_dq  = flash_byte(fl_addr);
  assign fl_dq0 = flash_byte(fl_addr0);

  flash_word_arbiter #(.WAIT_CYCLES(4), .ADDR_W(22)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .FL_ADDR(fl_addr), .FL_DQ(fl_dq), .FL_CE_N(fl_ce_n),
    .FL_OE_N(fl_oe_n), .FL_WE_N(fl_we_n), .FL_RST_N(fl_rst_n)
  );

  flash_word_arbiter #(.WAIT_CYCLES(0), .ADDR_W(22)) dut0 (
    .clk(clk), .Reset_n(Reset_n),
    .i_req_valid(i0_req_valid), .i_req_addr(i0_req_addr), .i_req_ready(i0_req_ready),
    .i_rsp_valid(i0_rsp_valid),
    .d_req_valid(1'b0), .d_req_addr(20'h0), .d_req_ready(d0_req_ready),
    .d_rsp_valid(d0_rsp_valid),
    .rsp_data(rsp_data0), .busy(busy0), .FL_ADDR(fl_addr0), .FL_DQ(fl_dq0), .FL_CE_N(fl_ce_n0),
    .FL_OE_N(fl_oe_n0), .FL_WE_N(fl_we_n0), .FL_RST_N(fl_rst_n0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Raise a request at a negedge, wait (bounded) for ready, then drop valid after the handshake.
  task automatic do_req(input bit is_d, input logic [19:0] addr);
    int n;
    n = 0;
    if (is_d) begin d_req_valid = 1'b1; d_req_addr = addr; end
    else begin i_req_valid = 1'b1; i_req_addr = addr; end
    #1;
    while (!(is_d ? d_req_ready : i_req_ready) && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk("req_accepted", 32'(n < 60), 32'd1);
    t_hs = cyc;
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0;
    else i_req_valid = 1'b0;
  endtask

  // Wait (bounded) for the port's response; check latency, data and no stray pulse on the other.
  task automatic wait_rsp(input bit is_d, input logic [31:0] exp_data, input string tag);
    int n;
    bit stray;
    n = 0;
    stray = 1'b0;
    do begin
      @(negedge clk); #1; n++;
      if (is_d ? i_rsp_valid : d_rsp_valid) stray = 1'b1;
    end while (!(is_d ? d_rsp_valid : i_rsp_valid) && n < 60);
    chk({tag, "_latency"}, 32'(cyc - t_hs), 32'd21);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_other_port_quiet"}, 32'(stray), 32'd0);
  endtask

  initial begin
    int got_d;
    // Reset state, with a request already pending that must not be accepted
    i_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_fl_addr", 32'(fl_addr), 32'h0);
    chk("rst_ce_n", 32'(fl_ce_n), 32'd1);
    chk("rst_oe_n", 32'(fl_oe_n), 32'd1);
    chk("rst_we_n", 32'(fl_we_n), 32'd1);
    chk("rst_fl_rst_n", 32'(fl_rst_n), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
    chk("rst_ready", 32'({i_req_ready, d_req_ready}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    i_req_valid = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    #1 chk("rel_fl_rst_n_low", 32'(fl_rst_n), 32'd0);
    @(negedge clk); #1;
    chk("rel_fl_rst_n_high", 32'(fl_rst_n), 32'd1);

    // Single fetch: byte address stepping and response timing
    @(negedge clk);
    do_req(1'b0, 20'h00010);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      chk("fetch_fl_addr", 32'(fl_addr), 32'h40 + 32'((c - 1) / 5));
      chk("fetch_ce_oe", 32'({fl_ce_n, fl_oe_n}), 32'd0);
      chk("fetch_no_rsp", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
    end
    @(negedge clk); #1;
    chk("fetch_i_rsp", 32'(i_rsp_valid), 32'd1);
    chk("fetch_d_rsp", 32'(d_rsp_valid), 32'd0);
    chk("fetch_data", rsp_data, 32'h8C220004);
    chk("fetch_done_ce", 32'(fl_ce_n), 32'd1);
    chk("fetch_latency", 32'(cyc - t_hs), 32'd21);
    @(negedge clk); #1;
    chk("fetch_pulse_one_cycle", 32'(i_rsp_valid), 32'd0);
    chk("fetch_idle", 32'(busy), 32'd0);
    chk("fetch_data_hold", rsp_data, 32'h8C220004);

    // Stall hold: D waits through an I read, then is served right after I's DONE
    do_req(1'b0, 20'h00010);
    d_req_valid = 1'b1;
    d_req_addr  = 20'h00002;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      chk("stall_d_ready_low", 32'(d_req_ready), 32'd0);
    end
    @(negedge clk); #1;
    chk("stall_i_done", 32'(i_rsp_valid), 32'd1);
    chk("stall_i_data", rsp_data, 32'h8C220004);
    chk("stall_d_ready_in_done", 32'(d_req_ready), 32'd0);
    @(negedge clk); #1;
    chk("stall_d_ready_after_done", 32'(d_req_ready), 32'd1);
    t_hs = cyc;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      chk("stall_rsp_data_held", rsp_data, 32'h8C220004);
    end
    wait_rsp(1'b1, 32'h22222222, "stall_d");

    // Reset mid-read during byte k=2
    @(negedge clk);
    do_req(1'b0, 20'h00010);
    repeat (12) @(negedge clk);
    #1 chk("midrst_byte2_addr", 32'(fl_addr), 32'h42);
    i_req_valid = 1'b1;
    Reset_n = 1'b0;
    #1;
    chk("midrst_ce_n", 32'(fl_ce_n), 32'd1);
    chk("midrst_oe_n", 32'(fl_oe_n), 32'd1);
    chk("midrst_fl_rst_n", 32'(fl_rst_n), 32'd0);
    chk("midrst_fl_addr", 32'(fl_addr), 32'h0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("midrst_no_rsp", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
    end
    Reset_n = 1'b1;
    #1 chk("midrst_ready_blocked", 32'(i_req_ready), 32'd0);
    @(negedge clk);
    do_req(1'b0, 20'h00010);
    wait_rsp(1'b0, 32'h8C220004, "midrst_refetch");

    // Simultaneous requests after reset: D first, then I, 22 cycles apart
    @(negedge clk);
    Reset_n = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 20'h00001;
    d_req_valid = 1'b1; d_req_addr = 20'h00002;
    #1;
    chk("simul_d_first", 32'({d_req_ready, i_req_ready}), 32'b10);
    t_hs = cyc;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    wait_rsp(1'b1, 32'h22222222, "simul_d");
    @(negedge clk); #1;
    chk("simul_i_next", 32'(i_req_ready), 32'd1);
    chk("simul_hs_spacing", 32'(cyc - t_hs), 32'd22);
    t_hs = cyc;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_rsp(1'b0, 32'h11111111, "simul_i");

    // Sustained contention: six words alternate D,I,D,I,D,I
    @(negedge clk);
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    for (int w = 0; w < 6; w++) begin
      int n;
      n = 0;
      #1;
      while (!(i_req_ready || d_req_ready) && n < 60) begin
        @(negedge clk); #1; n++;
      end
      chk("cont_single_grant", 32'(i_req_ready & d_req_ready), 32'd0);
      got_d = int'(d_req_ready);
      chk("cont_grant_port", 32'(got_d), (w % 2 == 0) ? 32'd1 : 32'd0);
      t_hs = cyc;
      wait_rsp(got_d != 0, (got_d != 0) ? 32'h22222222 : 32'h11111111, "cont");
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;

    // WAIT_CYCLES=0 build: top-of-flash word, one cycle per byte
    @(negedge clk);
    i0_req_valid = 1'b1;
    i0_req_addr  = 20'hFFFFF;
    #1 chk("w0_ready", 32'(i0_req_ready), 32'd1);
    t_hs = cyc;
    @(posedge clk); #1;
    i0_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      chk("w0_fl_addr", 32'(fl_addr0), 32'h3FFFFC + 32'(c - 1));
      chk("w0_no_rsp", 32'(i0_rsp_valid), 32'd0);
    end
    @(negedge clk); #1;
    chk("w0_rsp", 32'(i0_rsp_valid), 32'd1);
    chk("w0_latency", 32'(cyc - t_hs), 32'd5);
    chk("w0_data", rsp_data0, 32'hDEADBEEF);
    chk("w0_d_rsp", 32'(d0_rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
